// File: rtl/morse_symbol_timer.sv
// rtl/morse_symbol_timer.sv - Debounced Morse key timer emitting dot/dash/gap event pulses
//
// Optional feature macro: MORSE_TIMER_ERR_EN
//   When it is defined, a press that reaches DASH_MAX_UNITS raises err once.
//   That press is then dropped, so its release produces neither dot nor dash.
//   When it is undefined, err is held at 0.
//
// Ports:
//   clk        in   1       system clock
//   reset      in   1       asynchronous reset, active low
//   button     in   1       raw key, 1 = pressed, asynchronous to clk
//   dot        out  1       one-cycle pulse: dot symbol completed
//   dash       out  1       one-cycle pulse: dash symbol completed
//   interchar  out  1       one-cycle pulse: character gap reached
//   interword  out  1       one-cycle pulse: word gap reached
//   busy       out  1       1 while a press or gap is being timed
//   t          out  UNIT_W  completed units in the current press/gap (saturating)
//   err        out  1       one-cycle pulse: over-long press

module morse_symbol_timer #(
    parameter int CLKS_PER_UNIT  = 50000000,
    parameter int DEBOUNCE_CLKS  = 500000,
    parameter int UNIT_W         = 4,
    parameter int DOT_MAX_UNITS  = 2,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 5,
    parameter int DASH_MAX_UNITS = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    output logic              dot,
    output logic              dash,
    output logic              interchar,
    output logic              interword,
    output logic              busy,
    output logic [UNIT_W-1:0] t,
    output logic              err
);

    localparam int PW = $clog2(CLKS_PER_UNIT);
    localparam int DW = $clog2(DEBOUNCE_CLKS + 1);

`ifdef MORSE_TIMER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [PW-1:0]     PRESC_LAST = PW'(CLKS_PER_UNIT - 1);
    localparam logic [DW-1:0]     DB_LAST    = DW'(DEBOUNCE_CLKS - 1);
    localparam logic [UNIT_W-1:0] T_MAX      = '1;
    localparam logic [UNIT_W-1:0] DOT_T      = UNIT_W'(DOT_MAX_UNITS);
    localparam logic [UNIT_W-1:0] CHAR_T     = UNIT_W'(CHAR_GAP_UNITS);
    localparam logic [UNIT_W-1:0] WORD_T     = UNIT_W'(WORD_GAP_UNITS);
    localparam logic [UNIT_W-1:0] DASH_T     = UNIT_W'(DASH_MAX_UNITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    // Input path: synchroniser and debouncer
    logic          sync1_q, sync2_q;
    logic          kd_q, kd_d;
    logic          kd_prev_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;

    // Timing
    logic [PW-1:0]     presc_q, presc_d;
    logic [UNIT_W-1:0] t_q, t_d;

    // Control
    state_e state_q, state_d;
    logic   invalid_q, invalid_d;
    logic   dot_q, dot_d;
    logic   dash_q, dash_d;
    logic   ic_q, ic_d;
    logic   iw_q, iw_d;
    logic   err_q, err_d;

    // Derived combinational terms
    logic              kd_rise, kd_fall, kd_edge;
    logic              count_en, tick, t_step;
    logic [UNIT_W-1:0] t_inc, t_cls;

    // The debounced level moves only after DEBOUNCE_CLKS consecutive synced
    // samples that disagree with it; one agreeing sample restarts the run.
    always_comb begin
        kd_d     = kd_q;
        db_cnt_d = '0;
        if (sync2_q != kd_q) begin
            if (db_cnt_q == DB_LAST) begin
                kd_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // kd_prev_q lags kd_q by one clock, so the edge strobes are built from
    // registers only and every consumer sees the same cycle.
    assign kd_rise = kd_q & ~kd_prev_q;
    assign kd_fall = ~kd_q & kd_prev_q;
    assign kd_edge = kd_rise | kd_fall;

    // Time only runs while a press or gap is being measured. In IDLE the
    // counters hold, so t stays at its last value (0 after reset).
    assign count_en = (state_q != S_IDLE);
    assign tick     = count_en && (presc_q == PRESC_LAST);
    assign t_inc    = (t_q == T_MAX) ? t_q : t_q + 1'b1;
    assign t_step   = tick && (t_q != T_MAX);

    // A press is classified by t after this cycle's tick. This makes a
    // release that coincides with a unit boundary count the completed unit.
    assign t_cls = t_step ? t_inc : t_q;

    always_comb begin
        presc_d = presc_q;
        t_d     = t_q;
        if (kd_edge) begin
            presc_d = '0;
            t_d     = '0;
        end else if (count_en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (t_step) begin
                t_d = t_inc;
            end
        end
    end

    // A key edge always wins over a threshold tick in the same cycle.
    // A gap cut short by a new press therefore never reports the threshold it
    // was about to reach.
    always_comb begin
        state_d   = state_q;
        invalid_d = invalid_q;
        dot_d     = 1'b0;
        dash_d    = 1'b0;
        ic_d      = 1'b0;
        iw_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kd_rise) begin
                    state_d   = S_PRESS;
                    invalid_d = 1'b0;
                end
            end
            S_PRESS: begin
                if (kd_fall) begin
                    state_d = S_GAP;
                    if (!invalid_q) begin
                        // A release on the very tick that hits the long-press
                        // limit reports err here. The mid-press branch below
                        // never sees that tick.
                        if (ERR_EN && (t_cls >= DASH_T)) begin
                            err_d = 1'b1;
                        end else if (t_cls < DOT_T) begin
                            dot_d = 1'b1;
                        end else begin
                            dash_d = 1'b1;
                        end
                    end
                end else if (ERR_EN && !invalid_q && t_step && (t_inc == DASH_T)) begin
                    err_d     = 1'b1;
                    invalid_d = 1'b1;
                end
            end
            S_GAP: begin
                if (kd_rise) begin
                    state_d   = S_PRESS;
                    invalid_d = 1'b0;
                end else if (t_step && (t_inc == CHAR_T)) begin
                    ic_d = 1'b1;
                end else if (t_step && (t_inc == WORD_T)) begin
                    iw_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            kd_q      <= 1'b0;
            kd_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            presc_q   <= '0;
            t_q       <= '0;
            state_q   <= S_IDLE;
            invalid_q <= 1'b0;
            dot_q     <= 1'b0;
            dash_q    <= 1'b0;
            ic_q      <= 1'b0;
            iw_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            kd_q      <= kd_d;
            kd_prev_q <= kd_q;
            db_cnt_q  <= db_cnt_d;
            presc_q   <= presc_d;
            t_q       <= t_d;
            state_q   <= state_d;
            invalid_q <= invalid_d;
            dot_q     <= dot_d;
            dash_q    <= dash_d;
            ic_q      <= ic_d;
            iw_q      <= iw_d;
            err_q     <= err_d;
        end
    end

    assign dot       = dot_q;
    assign dash      = dash_q;
    assign interchar = ic_q;
    assign interword = iw_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign t         = t_q;

endmodule

// File: tb/tb_morse_symbol_timer.sv
// tb/tb_morse_symbol_timer.sv - Scoreboard bench for morse_symbol_timer against a duration-based model

`timescale 1ns/1ps

module tb_morse_symbol_timer;

    localparam int CPU  = 10;
    localparam int DB   = 3;
    localparam int UW   = 4;
    localparam int TSAT = 15;
    localparam int LAT  = 2 + DB + 1;
    localparam int DOTU = 2;
    localparam int CHRU = 3;
    localparam int WRDU = 5;
    localparam int DSHU = 7;

`ifdef MORSE_TIMER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int K_DOT = 0;
    localparam int K_DASH = 1;
    localparam int K_IC = 2;
    localparam int K_IW = 3;
    localparam int K_ERR = 4;

    typedef struct {
        int kind;
        int cyc;
        int tval;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          button = 1'b0;
    logic          dot, dash, interchar, interword, busy, err;
    logic [UW-1:0] t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    morse_symbol_timer #(
        .CLKS_PER_UNIT (CPU),
        .DEBOUNCE_CLKS (DB),
        .UNIT_W        (UW),
        .DOT_MAX_UNITS (DOTU),
        .CHAR_GAP_UNITS(CHRU),
        .WORD_GAP_UNITS(WRDU),
        .DASH_MAX_UNITS(DSHU)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .dot      (dot),
        .dash     (dash),
        .interchar(interchar),
        .interword(interword),
        .busy     (busy),
        .t        (t),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Units completed after 'elapsed' clocks since the raw key change.
    function automatic int t_model(int elapsed);
        int u;
        if (elapsed < LAT) return 0;
        u = (elapsed - LAT) / CPU;
        return (u > TSAT) ? TSAT : u;
    endfunction

    function automatic void push(int kind, int c, int tv);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.tval = tv;
        exp_q.push_back(e);
    endfunction

    // Press of plen clocks starting at raw cycle p.
    function automatic void expect_press(int p, int plen);
        int u;
        u = plen / CPU;
        if (u > TSAT) u = TSAT;
        if (ERR_EN && u >= DSHU) begin
            if (plen > CPU * DSHU) push(K_ERR, p + LAT + CPU * DSHU, DSHU);
            else push(K_ERR, p + plen + LAT, 0);
        end else if (u < DOTU) begin
            push(K_DOT, p + plen + LAT, 0);
        end else begin
            push(K_DASH, p + plen + LAT, 0);
        end
    endfunction

    // Gap of glen clocks starting at raw cycle r, ended by a new press.
    function automatic void expect_gap(int r, int glen);
        if (glen > CPU * CHRU) push(K_IC, r + LAT + CPU * CHRU, CHRU);
        if (glen > CPU * WRDU) push(K_IW, r + LAT + CPU * WRDU, WRDU);
    endfunction

    task automatic key(int plen, int glen, bit bounce);
        int p;
        int r;
        button = 1'b1;
        p = cyc;
        expect_press(p, plen);
        if (plen >= 180) begin
            repeat (180) @(posedge clk);
            #1;
            check("t_saturated_in_press", int'(t), t_model(cyc - p));
            repeat (plen - 180) @(posedge clk);
        end else begin
            repeat (plen) @(posedge clk);
        end
        #1;
        button = 1'b0;
        r = cyc;
        expect_gap(r, glen);
        if (bounce) begin
            repeat (4) @(posedge clk);
            #1;
            for (int i = 0; i < 20; i++) begin
                button = ~button;
                repeat (2) @(posedge clk);
                #1;
            end
            check("t_after_bounce", int'(t), t_model(cyc - r));
            check("busy_after_bounce", int'(busy), 1);
            repeat (glen - 44) @(posedge clk);
        end else begin
            repeat (glen) @(posedge clk);
        end
        #1;
    endtask

    function automatic int rand_press();
        int v;
        case ($urandom_range(0, 7))
            0: v = 19;
            1: v = 20;
            2: v = 69;
            3: v = 70;
            4: v = 71;
            default: v = $urandom_range(4, 110);
        endcase
        return v;
    endfunction

    function automatic int rand_gap();
        int v;
        case ($urandom_range(0, 6))
            0: v = 30;
            1: v = 31;
            2: v = 50;
            3: v = 51;
            default: v = $urandom_range(4, 70);
        endcase
        return v;
    endfunction

    // Monitor: every pulse pops one expectation and is checked against it.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        n = int'(dot) + int'(dash) + int'(interchar) + int'(interword) + int'(err);
        if (n != 0) begin
            kind = dot ? K_DOT : dash ? K_DASH : interchar ? K_IC : interword ? K_IW : K_ERR;
            if (n > 1) begin
                check("pulses_onehot", n, 1);
            end else if (exp_q.size() == 0) begin
                check("unexpected_event_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc, e.cyc);
                check("event_t", int'(t), e.tval);
                if (kind == K_IW) check("busy_at_interword", int'(busy), 0);
            end
        end
    end

    initial begin
        reset = 1'b0;
        button = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dot", int'(dot), 0);
        check("reset_dash", int'(dash), 0);
        check("reset_interchar", int'(interchar), 0);
        check("reset_interword", int'(interword), 0);
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_t", int'(t), 0);

        // Press aborted by reset: nothing may be reported for it.
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        button = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("busy_in_press", int'(busy), 1);
        reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_t", int'(t), 0);
        check("abort_pulses", int'(dot | dash | interchar | interword | err), 0);
        repeat (5) @(posedge clk);
        #1;
        button = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("idle_busy", int'(busy), 0);
        check("idle_t", int'(t), 0);

        key(35, 60, 1'b0);
        key(15, 15, 1'b0);
        key(15, 60, 1'b0);
        key(15, 60, 1'b1);
        key(200, 40, 1'b0);
        for (int k = 0; k < 12; k++) begin
            key(rand_press(), rand_gap(), 1'b0);
        end
        key(25, 80, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("final_busy", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
